// File: rtl/shift_pkg.sv
// Shared types for the iterative shift sequencer: op-class code, shift op encoding, FSM states.
package shift_pkg;

   localparam logic [2:0] SHIFT_REG = 3'b000;

   typedef enum logic [1:0] {
      SLL = 2'd0,
      SRL = 2'd1,
      SRA = 2'd2,
      ROR = 2'd3
   } shift_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_step.sv
// One shifter step: moves data by 1 position, or by 4 when by4 is set.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   input  shift_op_e        op,
   input  logic             by4,
   output logic [WIDTH-1:0] step_out
);

   always_comb begin
      step_out = data;
      case (op)
         SLL: step_out = by4 ? {data[WIDTH-5:0], 4'b0000} : {data[WIDTH-2:0], 1'b0};
         SRL: step_out = by4 ? {4'b0000, data[WIDTH-1:4]} : {1'b0, data[WIDTH-1:1]};
         SRA: step_out = by4 ? {{4{data[WIDTH-1]}}, data[WIDTH-1:4]}
                             : {data[WIDTH-1], data[WIDTH-1:1]};
         ROR: step_out = by4 ? {data[3:0], data[WIDTH-1:4]} : {data[0], data[WIDTH-1:1]};
         default: step_out = data;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer for the EX stage; iterates a one-step shifter instead of a barrel shifter.
// Define SHIFT_STEP4_EN to take 4-position steps while at least 4 positions remain.
//
// state | meaning
// IDLE  | waiting for a start strobe
// SHIFT | stepping data until the remaining count reaches zero
// DONE  | result_valid high for this cycle; a new start may be accepted here
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             enable_ex,
   input  logic [2:0]       control_in,
   input  logic [1:0]       shift_op,
   input  logic             amt_sel,
   input  logic [AMT_W-1:0] imm,
   input  logic [AMT_W-1:0] src2,
   input  logic [WIDTH-1:0] operand,
   input  logic             flush,
   output logic             busy,
   output logic [AMT_W-1:0] shift_number,
   output logic [WIDTH-1:0] result,
   output logic             result_valid
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] step_data;
   logic [AMT_W-1:0] cnt_q;
   logic [AMT_W-1:0] amount;
   logic [AMT_W-1:0] step_size;
   shift_op_e        op_q;
   logic             start;
   logic             cnt_zero;
   logic             by4;

   assign start    = enable_ex && (control_in == SHIFT_REG);
   assign amount   = amt_sel ? src2 : imm;
   assign cnt_zero = (cnt_q == '0);
   assign busy     = (state_q == SHIFT);

`ifdef SHIFT_STEP4_EN
   assign by4 = (cnt_q >= AMT_W'(4));
`else
   assign by4 = 1'b0;
`endif

   assign step_size = by4 ? AMT_W'(4) : AMT_W'(1);

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .data     (data_q),
      .op       (op_q),
      .by4      (by4),
      .step_out (step_data)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (cnt_zero) state_d = DONE;
         DONE:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q      <= IDLE;
         data_q       <= '0;
         cnt_q        <= '0;
         op_q         <= SLL;
         shift_number <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         state_q      <= state_d;
         result_valid <= 1'b0;
         if (flush) begin
            cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE, DONE: begin
                  if (start) begin
                     data_q       <= operand;
                     cnt_q        <= amount;
                     shift_number <= amount;
                     op_q         <= shift_op_e'(shift_op);
                  end
               end
               SHIFT: begin
                  if (!cnt_zero) begin
                     data_q <= step_data;
                     cnt_q  <= cnt_q - step_size;
                  end else begin
                     result       <= data_q;
                     result_valid <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed corner cases plus randomized ops vs an arithmetic model.
module tb_shift_sequencer;

   localparam int WIDTH = 32;
   localparam int AMT_W = 5;

   logic             CLOCK = 1'b0;
   logic             RESET;
   logic             enable_ex;
   logic [2:0]       control_in;
   logic [1:0]       shift_op;
   logic             amt_sel;
   logic [AMT_W-1:0] imm;
   logic [AMT_W-1:0] src2;
   logic [WIDTH-1:0] operand;
   logic             flush;
   logic             busy;
   logic [AMT_W-1:0] shift_number;
   logic [WIDTH-1:0] result;
   logic             result_valid;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [WIDTH-1:0] last_result;

   shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .enable_ex    (enable_ex),
      .control_in   (control_in),
      .shift_op     (shift_op),
      .amt_sel      (amt_sel),
      .imm          (imm),
      .src2         (src2),
      .operand      (operand),
      .flush        (flush),
      .busy         (busy),
      .shift_number (shift_number),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [WIDTH-1:0] model_result(input logic [1:0] op, input int n,
                                                     input logic [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] sx;
      sx = x;
      case (op)
         2'd0:    return x << n;
         2'd1:    return x >> n;
         2'd2:    return sx >>> n;
         default: return (n == 0) ? x : ((x >> n) | (x << (WIDTH - n)));
      endcase
   endfunction

   // edges from the accept edge to the result_valid edge
   function automatic int model_latency(input int n);
`ifdef SHIFT_STEP4_EN
      return n / 4 + n % 4 + 1;
`else
      return n + 1;
`endif
   endfunction

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic idle_inputs();
      enable_ex  = 1'b0;
      control_in = 3'($urandom_range(1, 7));
      flush      = 1'b0;
   endtask

   task automatic drive_start(input logic [1:0] op, input logic sel, input int amt,
                              input logic [WIDTH-1:0] opnd);
      shift_op = op;
      amt_sel  = sel;
      if (sel) begin
         src2 = AMT_W'(amt);
         imm  = AMT_W'($urandom);
      end else begin
         imm  = AMT_W'(amt);
         src2 = AMT_W'($urandom);
      end
      operand    = opnd;
      control_in = 3'b000;
      enable_ex  = 1'b1;
   endtask

   task automatic wait_valid(output int edges, output bit seen, input int budget);
      edges = 0;
      seen  = 1'b0;
      while (edges < budget && !seen) begin
         tick();
         edges++;
         if (result_valid) seen = 1'b1;
      end
   endtask

   task automatic count_pulses(output int pulses, input int cycles);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (result_valid) pulses++;
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic sel, input int amt,
                         input logic [WIDTH-1:0] opnd);
      logic [WIDTH-1:0] exp;
      int edges;
      bit seen;
      exp = model_result(op, amt, opnd);
      drive_start(op, sel, amt, opnd);
      tick();
      idle_inputs();
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL op_busy_after_accept: got %b want 1", busy);
      else pass_cnt++;
      wait_valid(edges, seen, 80);
      total_cnt++;
      if (!seen || edges != model_latency(amt))
         $display("FAIL op_latency op=%0d amt=%0d: got %0d seen=%0b want %0d", op, amt, edges, seen,
                  model_latency(amt));
      else pass_cnt++;
      total_cnt++;
      if (result !== exp)
         $display("FAIL op_result op=%0d amt=%0d opnd=%h: got %h want %h", op, amt, opnd, result, exp);
      else pass_cnt++;
      total_cnt++;
      if (shift_number !== AMT_W'(amt))
         $display("FAIL op_shift_number: got %0d want %0d", shift_number, amt);
      else pass_cnt++;
      last_result = exp;
      tick();
      total_cnt++;
      if (result_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL op_pulse_end: got valid=%b busy=%b want 0/0", result_valid, busy);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      idle_inputs();
      tick();
      tick();
      RESET = 1'b0;
      total_cnt++;
      if ({busy, result_valid, shift_number, result} !== '0)
         $display("FAIL reset_state: got busy=%b valid=%b num=%0d result=%h want all 0",
                  busy, result_valid, shift_number, result);
      else pass_cnt++;
      last_result = '0;
   endtask

   task automatic test_directed();
      run_op(2'd0, 1'b0, 5, 32'h0000_0001);
      total_cnt++;
      if (result !== 32'h0000_0020) $display("FAIL sll_const: got %h want 00000020", result);
      else pass_cnt++;
      run_op(2'd2, 1'b1, 31, 32'h8000_0000);
      total_cnt++;
      if (result !== 32'hFFFF_FFFF) $display("FAIL sra_const: got %h want ffffffff", result);
      else pass_cnt++;
      run_op(2'd3, 1'b0, 1, 32'h0000_0001);
      total_cnt++;
      if (result !== 32'h8000_0000) $display("FAIL ror_const: got %h want 80000000", result);
      else pass_cnt++;
      run_op(2'd1, 1'b1, 0, 32'hDEAD_BEEF);
      run_op(2'd0, 1'b0, 13, 32'h0000_0001);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         run_op(2'($urandom), 1'($urandom), int'($urandom_range(0, 31)), $urandom);
   endtask

   task automatic test_no_start();
      int pulses;
      enable_ex  = 1'b1;
      control_in = 3'($urandom_range(1, 7));
      operand    = $urandom;
      tick();
      idle_inputs();
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL wrong_class_start: got busy=%b want 0", busy);
      else pass_cnt++;
      count_pulses(pulses, 10);
      total_cnt++;
      if (pulses != 0) $display("FAIL wrong_class_valid: got %0d pulses want 0", pulses);
      else pass_cnt++;
   endtask

   task automatic test_busy_ignore();
      logic [WIDTH-1:0] opnd;
      int edges;
      int pulses;
      bit seen;
      opnd = $urandom;
      drive_start(2'd1, 1'b0, 10, opnd);
      tick();
      idle_inputs();
      tick();
      tick();
      tick();
      drive_start(2'd0, 1'b1, 2, ~opnd);
      tick();
      idle_inputs();
      wait_valid(edges, seen, 60);
      total_cnt++;
      if (!seen || edges + 4 != model_latency(10))
         $display("FAIL ignore_latency: got %0d seen=%0b want %0d", edges + 4, seen, model_latency(10));
      else pass_cnt++;
      total_cnt++;
      if (result !== model_result(2'd1, 10, opnd) || shift_number !== AMT_W'(10))
         $display("FAIL ignore_result: got %h/%0d want %h/10", result, shift_number,
                  model_result(2'd1, 10, opnd));
      else pass_cnt++;
      last_result = model_result(2'd1, 10, opnd);
      count_pulses(pulses, 20);
      total_cnt++;
      if (pulses != 0) $display("FAIL ignore_extra_valid: got %0d pulses want 0", pulses);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] a, b;
      int edges;
      bit seen;
      a = $urandom;
      b = $urandom;
      drive_start(2'd2, 1'b0, 3, a);
      tick();
      idle_inputs();
      wait_valid(edges, seen, 40);
      total_cnt++;
      if (!seen || result !== model_result(2'd2, 3, a))
         $display("FAIL b2b_first: got %h seen=%0b want %h", result, seen, model_result(2'd2, 3, a));
      else pass_cnt++;
      drive_start(2'd3, 1'b1, 7, b);
      tick();
      idle_inputs();
      total_cnt++;
      if (busy !== 1'b1 || result_valid !== 1'b0)
         $display("FAIL b2b_accept: got busy=%b valid=%b want 1/0", busy, result_valid);
      else pass_cnt++;
      wait_valid(edges, seen, 40);
      total_cnt++;
      if (!seen || edges != model_latency(7) || result !== model_result(2'd3, 7, b))
         $display("FAIL b2b_second: got lat=%0d res=%h want lat=%0d res=%h", edges, result,
                  model_latency(7), model_result(2'd3, 7, b));
      else pass_cnt++;
      last_result = model_result(2'd3, 7, b);
      tick();
   endtask

   task automatic test_flush();
      int pulses;
      drive_start(2'd0, 1'b0, 10, $urandom);
      tick();
      idle_inputs();
      tick();
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || result_valid !== 1'b0 || result !== last_result || shift_number !== AMT_W'(10))
         $display("FAIL flush_state: got busy=%b valid=%b res=%h num=%0d want 0/0/%h/10",
                  busy, result_valid, result, shift_number, last_result);
      else pass_cnt++;
      count_pulses(pulses, 20);
      total_cnt++;
      if (pulses != 0) $display("FAIL flush_no_valid: got %0d pulses want 0", pulses);
      else pass_cnt++;
      drive_start(2'd1, 1'b0, 4, $urandom);
      flush = 1'b1;
      tick();
      idle_inputs();
      total_cnt++;
      if (busy !== 1'b0 || shift_number !== AMT_W'(10))
         $display("FAIL flush_start_drop: got busy=%b num=%0d want 0/10", busy, shift_number);
      else pass_cnt++;
      count_pulses(pulses, 10);
      total_cnt++;
      if (pulses != 0) $display("FAIL flush_start_valid: got %0d pulses want 0", pulses);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int pulses;
      drive_start(2'd3, 1'b1, 10, $urandom | 32'h1);
      tick();
      idle_inputs();
      tick();
      tick();
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      total_cnt++;
      if ({busy, result_valid, shift_number, result} !== '0)
         $display("FAIL reset_mid: got busy=%b valid=%b num=%0d res=%h want all 0",
                  busy, result_valid, shift_number, result);
      else pass_cnt++;
      count_pulses(pulses, 20);
      total_cnt++;
      if (pulses != 0) $display("FAIL reset_mid_valid: got %0d pulses want 0", pulses);
      else pass_cnt++;
      last_result = '0;
   endtask

   initial begin
      RESET    = 1'b1;
      shift_op = 2'd0;
      amt_sel  = 1'b0;
      imm      = '0;
      src2     = '0;
      operand  = '0;
      idle_inputs();
      test_reset();
      test_directed();
      test_random();
      test_no_start();
      test_busy_ignore();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      run_op(2'd2, 1'b0, 31, $urandom);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
